// File: rtl/ox_sequencer.sv
// Round-robin emitter sequencer: ON window, dark window and a result slot per channel.
// Averages ADC samples in each window and reports an ambient-corrected, gain-scaled reading.
module ox_sequencer #(
   parameter int          NUM_CH        = 2,
   parameter int          ADC_WIDTH     = 8,
   parameter int          OUT_W         = 16,
   parameter int          ON_CYCLES     = 20_000_000,
   parameter int          OFF_CYCLES    = 5_000_000,
   parameter int          SETTLE_CYCLES = 1000,
   parameter int          AVG_LOG2      = 2,
   parameter int unsigned GAIN          = 1,
   parameter int          THRESH_HI     = 95,
   parameter int          THRESH_LO     = 90,
   localparam int         CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [ADC_WIDTH-1:0] adc_data,
   input  logic                 adc_valid,
   output logic [NUM_CH-1:0]    laser,
   output logic                 busy,
   output logic [OUT_W-1:0]     ch_data,
   output logic [CH_W-1:0]      ch_id,
   output logic                 data_valid,
   output logic                 underrun,
   output logic [NUM_CH-1:0]    alarm
);

   // state    | meaning
   // S_IDLE   | stopped, emitters off, waiting for en
   // S_ON     | emitter ch lit, ON-window samples accumulated
   // S_OFF    | all emitters dark, ambient samples accumulated
   // S_RESULT | one cycle: correct, scale, publish or flag underrun

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_RESULT} state_t;

   localparam int MAX_LEN = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int CNT_W   = $clog2(MAX_LEN + 1);
   localparam int ACC_W   = ADC_WIDTH + AVG_LOG2;
   localparam int N_W     = AVG_LOG2 + 1;
   localparam int PROD_W  = ADC_WIDTH + 32;

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
   // Down-counter values at or below these mark window index k >= SETTLE_CYCLES.
   localparam logic [CNT_W-1:0] ON_SAMP  = CNT_W'(ON_CYCLES - 1 - SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] OFF_SAMP = CNT_W'(OFF_CYCLES - 1 - SETTLE_CYCLES);
   localparam logic [N_W-1:0]   N_SAMP   = N_W'(1 << AVG_LOG2);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

   state_t              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ACC_W-1:0]    on_acc_q, on_acc_d, off_acc_q, off_acc_d;
   logic [N_W-1:0]      on_n_q, on_n_d, off_n_q, off_n_d;
   logic [NUM_CH-1:0]   laser_q, laser_d, alarm_q, alarm_d;
   logic                busy_q, busy_d, dv_q, dv_d, uf_q, uf_d;
   logic [OUT_W-1:0]    ch_data_q, ch_data_d;
   logic [CH_W-1:0]     ch_id_q, ch_id_d;

   logic [ADC_WIDTH-1:0] on_avg, off_avg, diff;
   logic [PROD_W-1:0]    prod;
   logic [OUT_W-1:0]     result;
   logic                 short_win;

   always_comb begin
      on_avg    = on_acc_q[ACC_W-1:AVG_LOG2];
      off_avg   = off_acc_q[ACC_W-1:AVG_LOG2];
      diff      = (on_avg > off_avg) ? (on_avg - off_avg) : '0;
      prod      = PROD_W'(diff) * PROD_W'(GAIN);
      result    = (|prod[PROD_W-1:OUT_W]) ? '1 : prod[OUT_W-1:0];
      short_win = (on_n_q != N_SAMP) || (off_n_q != N_SAMP);
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      cnt_d     = cnt_q;
      on_acc_d  = on_acc_q;
      off_acc_d = off_acc_q;
      on_n_d    = on_n_q;
      off_n_d   = off_n_q;
      ch_data_d = ch_data_q;
      ch_id_d   = ch_id_q;
      alarm_d   = alarm_q;
      dv_d      = 1'b0;
      uf_d      = 1'b0;
      laser_d   = '0;

      if (state_q == S_IDLE) begin
         if (en) begin
            state_d  = S_ON;
            ch_d     = '0;
            cnt_d    = ON_LAST;
            on_acc_d = '0;
            on_n_d   = '0;
         end
      end else if (!en) begin
         // Abort drops the slot silently; published data and alarms are kept.
         state_d   = S_IDLE;
         ch_d      = '0;
         cnt_d     = '0;
         on_acc_d  = '0;
         off_acc_d = '0;
         on_n_d    = '0;
         off_n_d   = '0;
      end else begin
         case (state_q)
            S_ON: begin
               if (adc_valid && (cnt_q <= ON_SAMP) && (on_n_q < N_SAMP)) begin
                  on_acc_d = on_acc_q + ACC_W'(adc_data);
                  on_n_d   = on_n_q + 1'b1;
               end
               if (cnt_q == '0) begin
                  state_d   = S_OFF;
                  cnt_d     = OFF_LAST;
                  off_acc_d = '0;
                  off_n_d   = '0;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            S_OFF: begin
               if (adc_valid && (cnt_q <= OFF_SAMP) && (off_n_q < N_SAMP)) begin
                  off_acc_d = off_acc_q + ACC_W'(adc_data);
                  off_n_d   = off_n_q + 1'b1;
               end
               if (cnt_q == '0) state_d = S_RESULT;
               else             cnt_d   = cnt_q - 1'b1;
            end
            S_RESULT: begin
               if (short_win) begin
                  uf_d = 1'b1;
               end else begin
                  dv_d      = 1'b1;
                  ch_data_d = result;
                  ch_id_d   = ch_q;
                  if (result > OUT_W'(THRESH_HI))      alarm_d[ch_q] = 1'b1;
                  else if (result < OUT_W'(THRESH_LO)) alarm_d[ch_q] = 1'b0;
               end
               state_d  = S_ON;
               ch_d     = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
               cnt_d    = ON_LAST;
               on_acc_d = '0;
               on_n_d   = '0;
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (state_d == S_ON) laser_d[ch_d] = 1'b1;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ch_q      <= '0;
         cnt_q     <= '0;
         on_acc_q  <= '0;
         off_acc_q <= '0;
         on_n_q    <= '0;
         off_n_q   <= '0;
         laser_q   <= '0;
         busy_q    <= 1'b0;
         ch_data_q <= '0;
         ch_id_q   <= '0;
         dv_q      <= 1'b0;
         uf_q      <= 1'b0;
         alarm_q   <= '0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         cnt_q     <= cnt_d;
         on_acc_q  <= on_acc_d;
         off_acc_q <= off_acc_d;
         on_n_q    <= on_n_d;
         off_n_q   <= off_n_d;
         laser_q   <= laser_d;
         busy_q    <= busy_d;
         ch_data_q <= ch_data_d;
         ch_id_q   <= ch_id_d;
         dv_q      <= dv_d;
         uf_q      <= uf_d;
         alarm_q   <= alarm_d;
      end
   end

   assign laser      = laser_q;
   assign busy       = busy_q;
   assign ch_data    = ch_data_q;
   assign ch_id      = ch_id_q;
   assign data_valid = dv_q;
   assign underrun   = uf_q;
   assign alarm      = alarm_q;

endmodule

// File: doc/ox_sequencer.md
Name: ox_sequencer

Overview:
- Multi-channel optical sensor sequencer for the blood-oxygen front end.
- Drives NUM_CH emitters round-robin, each with an ON window followed by a dark (ambient) window, and averages ADC samples in both windows.
- Reports an ambient-corrected, gain-scaled reading per channel, with a per-channel alarm that has hysteresis.
- Sits between the ADC interface and the display/telemetry logic, replacing fixed two-laser timing with cycle-programmable timing.

Parameters:
- NUM_CH, 2, number of emitter channels (>=1).
- ADC_WIDTH, 8, adc_data width.
- OUT_W, 16, ch_data width.
- ON_CYCLES, 20_000_000, clock cycles per ON window.
- OFF_CYCLES, 5_000_000, clock cycles per dark window.
- SETTLE_CYCLES, 1000, cycles ignored at the start of each window; must be < min(ON_CYCLES, OFF_CYCLES).
- AVG_LOG2, 2, log2 of the number of samples averaged per window.
- GAIN, 1, unsigned multiplier applied to the corrected value.
- THRESH_HI, 95, alarm set level (result > THRESH_HI).
- THRESH_LO, 90, alarm clear level (result < THRESH_LO); THRESH_LO <= THRESH_HI.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  run enable
- adc_data  in  ADC_WIDTH  ADC sample
- adc_valid  in  1  adc_data valid this cycle
- laser  out  NUM_CH  emitter drives, one-hot or zero
- busy  out  1  sequencer not in IDLE
- ch_data  out  OUT_W  corrected reading
- ch_id  out  max(1,$clog2(NUM_CH))  channel of ch_data
- data_valid  out  1  one-cycle strobe: ch_data/ch_id updated
- underrun  out  1  one-cycle strobe: window ended with too few samples
- alarm  out  NUM_CH  per-channel hysteretic alarm

Behaviour:
- Reset: all outputs 0, state IDLE, channel index 0, accumulators and counters cleared. rst has priority over en.
- FSM states: IDLE, ON, OFF, RESULT. All outputs are registered.
- IDLE -> ON on the first clk edge where en=1, with ch=0.
- ON: exactly ON_CYCLES cycles; laser[ch]=1 for exactly those cycles; all other laser bits 0.
- OFF: exactly OFF_CYCLES cycles; laser=0.
- RESULT: one cycle; laser=0. Then next ON with ch = (ch==NUM_CH-1) ? 0 : ch+1.
- Slot period = ON_CYCLES+OFF_CYCLES+1.
- Sampling:
  - Window cycle index k runs 0..len-1. A sample is accepted when adc_valid=1, k>=SETTLE_CYCLES, and fewer than 2^AVG_LOG2 samples have been taken in this window.
  - Later samples in the window are ignored.
  - Accumulator width is ADC_WIDTH+AVG_LOG2; it clears at the start of each window.
- Arithmetic (RESULT cycle):
  - on_avg = on_acc>>AVG_LOG2; off_avg = off_acc>>AVG_LOG2.
  - diff = on_avg - off_avg, clamped to 0 if negative.
  - result = diff*GAIN, saturated to 2^OUT_W-1.
- Output timing: ch_data, ch_id and data_valid=1 are visible in the cycle after RESULT, i.e. 2 cycles after the last OFF cycle. data_valid is high for exactly 1 cycle.
- Alarm, updated in the same cycle as data_valid:
  - result > THRESH_HI: alarm[ch] <= 1.
  - result < THRESH_LO: alarm[ch] <= 0.
  - Otherwise alarm[ch] holds.
- Underrun: if either window ended with fewer than 2^AVG_LOG2 accepted samples, then in the cycle after RESULT:
  - data_valid stays 0 and underrun=1 for 1 cycle.
  - ch_data, ch_id and alarm hold.
  - Sequencing continues normally.
- en deasserted in any non-IDLE state:
  - Next edge: state IDLE, laser=0, busy=0, accumulators and counters cleared, no data_valid or underrun for the aborted slot.
  - ch_data, ch_id and alarm hold.
  - Re-enable restarts at ch=0.
- busy = (state != IDLE), registered alongside the state.

Test Plan (NUM_CH=2, ON=20, OFF=10, SETTLE=4, AVG_LOG2=2, GAIN=1, HI=95, LO=90, adc_valid=1 unless stated):
1. Sequencing, adc_data=0, en=1 at t0:
   - laser=01 for 20 cycles, then 00 for 11, then 10 for 20, then 00 for 11.
   - data_valid at cycles 32 and 63 after start, with ch_id 0 then 1 and ch_data=0.
   - Pattern repeats from ch0.
2. Averaging and settle:
   - ON k=0..3 drive 255 (ignored); k=4..7 drive 100,102,104,106; k>=8 drive 200 (ignored).
   - OFF drives 10.
   - Expect ch_data=93, alarm[0]=0.
3. Hysteresis on ch0, successive results 96, 92, 89 -> alarm[0] = 1, 1, 0; alarm[1] unaffected.
4. Clamp and saturation:
   - on_avg=5, off_avg=20 -> ch_data=0.
   - GAIN=512 with diff=200 -> ch_data=65535.
5. Underrun:
   - Only 3 adc_valid pulses at k>=4 in ch0 ON -> underrun=1 for 1 cycle, no data_valid, ch_data and alarm unchanged.
   - ch1 slot then completes normally.
6. Abort and reset:
   - en=0 at ON k=10 -> laser=00 and busy=0 next cycle, no strobe; en=1 -> restart at ch0 with a full 20-cycle ON.
   - rst=1 mid-OFF -> all outputs 0 next cycle, including alarm and ch_data.
